// File: rtl/nibble_demux_loader_pkg.sv
// Shared types and constants for the two-press nibble-to-byte loader.
package nibble_demux_loader_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic {
    WAIT_HIGH = 1'b0,
    WAIT_LOW  = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_demux_loader_if.sv
// Button/DIP inputs and the assembled-byte outputs of the nibble loader.
interface nibble_demux_loader_if;

  logic       loadButton;
  logic [3:0] nibbleIn;
  logic [3:0] nibbleHigh;
  logic [3:0] nibbleLow;
  logic [7:0] byteOut;
  logic       byteValid;
  logic       loadingHigh;

  modport master (
    output loadButton, nibbleIn,
    input  nibbleHigh, nibbleLow, byteOut, byteValid, loadingHigh
  );

  modport slave (
    input  loadButton, nibbleIn,
    output nibbleHigh, nibbleLow, byteOut, byteValid, loadingHigh
  );

endinterface

// File: rtl/nibble_demux_loader_button_debouncer.sv
// Two-flop synchronizer, counter debouncer and rising-edge detector for a raw button.
module button_debouncer
  import nibble_demux_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic rawIn,
  output logic pressPulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       sync_q,     sync_d;
  logic             deb_q,      deb_d;
  logic             deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    sync_d     = {sync_q[0], rawIn};
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    cnt_d      = cnt_q;
    if (sync_q[1] == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = ~deb_q;
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
    end
  end

  // Only the press (rising) edge of the clean level loads a nibble.
  assign pressPulse = deb_q & ~deb_prev_q;

endmodule

// File: rtl/nibble_demux_loader.sv
// Loads a byte from two debounced button presses: upper nibble first, then lower.
module nibble_demux_loader
  import nibble_demux_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic                  clock,
  input logic                  reset,
  nibble_demux_loader_if.slave bus
);

  logic       load_pulse;
  state_e     state_q,       state_d;
  logic [3:0] nibble_high_q, nibble_high_d;
  logic [3:0] nibble_low_q,  nibble_low_d;
  logic [7:0] byte_out_q,    byte_out_d;
  logic       byte_valid_q,  byte_valid_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debouncer (
    .clock      (clock),
    .reset      (reset),
    .rawIn      (bus.loadButton),
    .pressPulse (load_pulse)
  );

  always_comb begin
    state_d       = state_q;
    nibble_high_d = nibble_high_q;
    nibble_low_d  = nibble_low_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    case (state_q)
      WAIT_HIGH: begin
        if (load_pulse) begin
          nibble_high_d = bus.nibbleIn;
          state_d       = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        // The byte is assembled from the live switches, not the not-yet-updated low register.
        if (load_pulse) begin
          nibble_low_d = bus.nibbleIn;
          byte_out_d   = {nibble_high_q, bus.nibbleIn};
          byte_valid_d = 1'b1;
          state_d      = WAIT_HIGH;
        end
      end
      default: state_d = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= WAIT_HIGH;
      nibble_high_q <= '0;
      nibble_low_q  <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      nibble_high_q <= nibble_high_d;
      nibble_low_q  <= nibble_low_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
    end
  end

  assign bus.nibbleHigh  = nibble_high_q;
  assign bus.nibbleLow   = nibble_low_q;
  assign bus.byteOut     = byte_out_q;
  assign bus.byteValid   = byte_valid_q;
  assign bus.loadingHigh = (state_q == WAIT_HIGH);

endmodule
